// File: rtl/multi_seq_detector_pkg.sv
// Shared limits and the length-width helper for the multi-pattern sequence detector.
package multi_seq_detector_pkg;

  localparam int unsigned MAX_NUM_PAT = 8;
  localparam int unsigned MAX_MAX_LEN = 16;

  // Width that can hold every length 0..max_len, so out-of-range lengths are representable.
  function automatic int unsigned len_w(input int unsigned max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/multi_seq_detector_if.sv
// Stream, configuration and result signals of the multi-pattern sequence detector.
interface multi_seq_detector_if
  import multi_seq_detector_pkg::*;
#(
  parameter int unsigned NUM_PAT = 2,
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned LEN_W   = len_w(MAX_LEN)
);

  logic                       din_valid;
  logic                       din;
  logic                       clear;
  logic                       overlap;
  logic [NUM_PAT-1:0]         cfg_en;
  logic [NUM_PAT*MAX_LEN-1:0] cfg_pat;
  logic [NUM_PAT*LEN_W-1:0]   cfg_len;
  logic [NUM_PAT-1:0]         match;
  logic                       y;
  logic [NUM_PAT*CNT_W-1:0]   match_cnt;

  modport master (
    output din_valid, din, clear, overlap, cfg_en, cfg_pat, cfg_len,
    input  match, y, match_cnt
  );

  modport slave (
    input  din_valid, din, clear, overlap, cfg_en, cfg_pat, cfg_len,
    output match, y, match_cnt
  );

endinterface

// File: rtl/multi_seq_detector_seq_match_chan.sv
// One detector channel: fill tracking, masked pattern compare, Mealy match and
// saturating match counter.
module seq_match_chan
  import multi_seq_detector_pkg::*;
#(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned LEN_W   = len_w(MAX_LEN)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_din_valid,
  input  logic               i_clear,
  input  logic               i_overlap,
  input  logic               i_en,
  input  logic [MAX_LEN-1:0] i_win,
  input  logic [MAX_LEN-1:0] i_pat,
  input  logic [LEN_W-1:0]   i_len,
  output logic               o_match,
  output logic [CNT_W-1:0]   o_cnt
);

  logic [LEN_W-1:0]   r_fill;
  logic [LEN_W-1:0]   w_fill_d;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_d;
  logic [MAX_LEN-1:0] w_mask;
  logic               w_accept;
  logic               w_len_ok;
  logic               w_fill_ok;
  logic               w_pat_eq;

  assign w_accept = i_din_valid & ~i_clear;

  always_comb begin
    w_mask = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      w_mask[i] = (i < 32'(i_len));
    end
  end

  assign w_len_ok = (i_len != '0) && (32'(i_len) <= MAX_LEN);
  // fill >= len-1, written as fill+1 >= len to avoid underflow at len=0.
  assign w_fill_ok = ({1'b0, r_fill} + (LEN_W + 1)'(1)) >= {1'b0, i_len};
  assign w_pat_eq  = ((i_win ^ i_pat) & w_mask) == '0;
  assign o_match   = w_accept & i_en & w_len_ok & w_fill_ok & w_pat_eq;

  always_comb begin
    w_fill_d = r_fill;
    if (i_clear) begin
      w_fill_d = '0;
    end else if (w_accept) begin
      if (o_match && !i_overlap) begin
        w_fill_d = '0;
      end else if (r_fill != LEN_W'(MAX_LEN)) begin
        w_fill_d = r_fill + LEN_W'(1);
      end
    end
  end

  always_comb begin
    w_cnt_d = r_cnt;
    if (i_clear) begin
      w_cnt_d = '0;
    end else if (o_match && (r_cnt != '1)) begin
      w_cnt_d = r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fill <= '0;
      r_cnt  <= '0;
    end else begin
      r_fill <= w_fill_d;
      r_cnt  <= w_cnt_d;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/multi_seq_detector.sv
// Multi-pattern Mealy sequence detector: shared bit history feeding NUM_PAT
// independently programmed match channels.
module multi_seq_detector
  import multi_seq_detector_pkg::*;
#(
  parameter int unsigned NUM_PAT = 2,
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned CNT_W   = 8
) (
  input logic                 i_clk,
  input logic                 i_rst_n,
  multi_seq_detector_if.slave io_bus
);

  localparam int unsigned LEN_W = len_w(MAX_LEN);

  if (NUM_PAT < 1 || NUM_PAT > MAX_NUM_PAT) begin : g_bad_num_pat
    $error("NUM_PAT out of range");
  end
  if (MAX_LEN < 2 || MAX_LEN > MAX_MAX_LEN) begin : g_bad_max_len
    $error("MAX_LEN out of range");
  end

  logic [MAX_LEN-2:0] r_hist;
  logic [MAX_LEN-1:0] w_win;
  logic               w_accept;
  logic [NUM_PAT-1:0] w_match;
  logic [CNT_W-1:0]   w_cnt [NUM_PAT];

  assign w_accept = io_bus.din_valid & ~io_bus.clear;
  assign w_win    = {r_hist, io_bus.din};

  // Idle cycles hold the history so a sequence may span gaps in din_valid.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hist <= '0;
    end else if (io_bus.clear) begin
      r_hist <= '0;
    end else if (w_accept) begin
      r_hist <= w_win[MAX_LEN-2:0];
    end
  end

  for (genvar k = 0; k < NUM_PAT; k++) begin : g_chan
    seq_match_chan #(
      .MAX_LEN (MAX_LEN),
      .CNT_W   (CNT_W),
      .LEN_W   (LEN_W)
    ) u_chan (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_din_valid (io_bus.din_valid),
      .i_clear     (io_bus.clear),
      .i_overlap   (io_bus.overlap),
      .i_en        (io_bus.cfg_en[k]),
      .i_win       (w_win),
      .i_pat       (io_bus.cfg_pat[k*MAX_LEN +: MAX_LEN]),
      .i_len       (io_bus.cfg_len[k*LEN_W +: LEN_W]),
      .o_match     (w_match[k]),
      .o_cnt       (w_cnt[k])
    );
  end

  always_comb begin
    io_bus.match_cnt = '0;
    for (int unsigned k = 0; k < NUM_PAT; k++) begin
      io_bus.match_cnt[k*CNT_W +: CNT_W] = w_cnt[k];
    end
  end

  assign io_bus.match = w_match;
  assign io_bus.y     = |w_match;

endmodule
